gate_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 1-bit two-input gate among N_REQ requesters. The shared gate is an and_gate-style unit with inputs gate_a, gate_b and output gate_c. Each requester presents one operand pair and holds a request. The block grants one requester at a time, drives that requester's operands to the gate, captures the result and returns it with a one-cycle response pulse. It sits between the requester logic and the single shared gate instance.

---
 rtl/gate_arb_pkg.sv | 18 +
 rtl/gate_share_arbiter_if.sv | 36 +++
 rtl/and_gate.sv | 11 +
 rtl/gate_share_arbiter_rr_pick.sv | 34 +++
 rtl/gate_share_arbiter.sv | 110 +++++++++++
 tb/tb_gate_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the gate sharing arbiter.
// Holds FSM state encoding and default sizing.
package gate_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_ISSUE = ISSUE,
    S_RESP  = RESP
  } state_t;

endpackage

// File: rtl/gate_share_arbiter_if.sv
// Requester and shared-gate bundle for gate_share_arbiter.
// master: requesters + gate; slave: the arbiter.
interface gate_share_arbiter_if
  import gate_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] a_in;
  logic [N_REQ-1:0] b_in;
  logic [N_REQ-1:0] gnt;
  logic             gate_a;
  logic             gate_b;
  logic             gate_c;
  logic [N_REQ-1:0] rsp_valid;
  logic             rsp_data;
  logic             busy;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output req, a_in, b_in, gate_c,
    input  gnt, gate_a, gate_b,
    input  rsp_valid, rsp_data,
    input  busy, txn_count
  );

  modport slave (
    input  req, a_in, b_in, gate_c,
    output gnt, gate_a, gate_b,
    output rsp_valid, rsp_data,
    output busy, txn_count
  );

endinterface

// File: rtl/and_gate.sv
// Shared 1-bit two-input AND unit used by the requesters.
// Ports: a, b in; c = a & b out (combinational).
module and_gate (
  input  logic a,
  input  logic b,
  output logic c
);

  assign c = a & b;

endmodule

// File: rtl/gate_share_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit from ptr upward.
// Ports: req, ptr in; any, win_idx out (combinational).
module rr_pick
  import gate_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] win_idx
);

  localparam int PTR_W = $clog2(N_REQ);

  int idx;

  // Scan from the farthest slot back to ptr so the
  // nearest set bit is the last one written.
  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        any     = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin sequencer sharing one 1-bit gate among requesters.
// Ports: clk, rst (sync, high), bus (slave side of the bundle).
module gate_share_arbiter
  import gate_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  gate_share_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rv_q, rv_d;
  logic             ga_q, ga_d;
  logic             gb_q, gb_d;
  logic             rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any;
  logic [PTR_W-1:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    rv_d    = rv_q;
    ga_d    = ga_q;
    gb_d    = gb_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_ISSUE;
          win_d   = pick_idx;
          gnt_d   = ONE << pick_idx;
          ga_d    = bus.a_in[pick_idx];
          gb_d    = bus.b_in[pick_idx];
        end
      end
      S_ISSUE: begin
        state_d = S_RESP;
        gnt_d   = '0;
        rv_d    = ONE << win_q;
        rd_d    = bus.gate_c;
        ptr_d   = (win_q == LAST) ? '0 : win_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        rv_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        rv_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      rv_q    <= '0;
      ga_q    <= 1'b0;
      gb_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      ga_q    <= ga_d;
      gb_q    <= gb_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gate_a    = ga_q;
  assign bus.gate_b    = gb_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rd_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.txn_count = cnt_q;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Directed bench for gate_share_arbiter with a real and_gate.
// Drives and samples 1 time unit after each rising edge.
module tb_gate_share_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  gate_share_arbiter_if #(.N_REQ(4), .CNT_W(8)) bus ();

  gate_share_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  and_gate u_gate (
    .a (bus.gate_a),
    .b (bus.gate_b),
    .c (bus.gate_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (bus.gnt !== 4'b0000) begin
      bad++;
      $display("FAIL rst_gnt got %b want 0000", bus.gnt);
    end
    total++;
    if (bus.rsp_valid !== 4'b0000) begin
      bad++;
      $display("FAIL rst_rv got %b want 0000", bus.rsp_valid);
    end
    total++;
    if ({bus.busy, bus.gate_a, bus.gate_b, bus.rsp_data} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_bits got %b%b%b%b want 0000",
               bus.busy, bus.gate_a, bus.gate_b, bus.rsp_data);
    end
    total++;
    if (bus.txn_count !== 8'd0) begin
      bad++;
      $display("FAIL rst_cnt got %0d want 0", bus.txn_count);
    end
  endtask

  // results per requester: a & b = 1010 -> 0:0 1:1 2:0 3:1
  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] dat;
    dat = 4'b1010;
    bus.a_in = 4'b1011;
    bus.b_in = 4'b1110;
    bus.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      total++;
      if (bus.gnt !== exp_g || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL rr_gnt[%0d] got %b busy %b want %b",
                 k, bus.gnt, bus.busy, exp_g);
      end
      step();
      total++;
      if (bus.rsp_valid !== exp_g || bus.gnt !== 4'b0000 ||
          bus.rsp_data !== dat[k % 4]) begin
        bad++;
        $display("FAIL rr_rsp[%0d] got rv %b gnt %b d %b want rv %b d %b",
                 k, bus.rsp_valid, bus.gnt, bus.rsp_data, exp_g, dat[k % 4]);
      end
      bus.req = bus.req & ~exp_g;
      step();
      total++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
        bad++;
        $display("FAIL rr_idle[%0d] got busy %b rv %b want 0 0000",
                 k, bus.busy, bus.rsp_valid);
      end
      bus.req = bus.req | exp_g;
    end
    bus.req = '0;
    total++;
    if (bus.txn_count !== 8'd5) begin
      bad++;
      $display("FAIL rr_cnt got %0d want 5", bus.txn_count);
    end
  endtask

  task automatic test_single();
    for (int r = 0; r < 2; r++) begin
      bus.req  = 4'b0100;
      bus.a_in = 4'b0100;
      bus.b_in = (r == 0) ? 4'b0100 : 4'b0000;
      step();
      total++;
      if (bus.gnt !== 4'b0100 || bus.gate_a !== 1'b1 ||
          bus.gate_b !== (r == 0)) begin
        bad++;
        $display("FAIL single_gnt[%0d] got %b a %b b %b want 0100",
                 r, bus.gnt, bus.gate_a, bus.gate_b);
      end
      step();
      total++;
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== (r == 0) ||
          bus.txn_count !== 8'(6 + r)) begin
        bad++;
        $display("FAIL single_rsp[%0d] got rv %b d %b c %0d want 0100 %0d %0d",
                 r, bus.rsp_valid, bus.rsp_data, bus.txn_count,
                 (r == 0), 6 + r);
      end
      bus.req = '0;
      step();
    end
  endtask

  // ptr is 3 here; results 3:1 0:0
  task automatic test_wrap();
    bus.req  = 4'b1001;
    bus.a_in = 4'b1001;
    bus.b_in = 4'b1000;
    step();
    total++;
    if (bus.gnt !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_g3 got %b want 1000", bus.gnt);
    end
    step();
    total++;
    if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 1'b1) begin
      bad++;
      $display("FAIL wrap_r3 got %b d %b want 1000 1",
               bus.rsp_valid, bus.rsp_data);
    end
    bus.req = 4'b0001;
    step();
    step();
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_g0 got %b want 0001", bus.gnt);
    end
    step();
    total++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 1'b0) begin
      bad++;
      $display("FAIL wrap_r0 got %b d %b want 0001 0",
               bus.rsp_valid, bus.rsp_data);
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_operand_latch();
    bus.req  = 4'b0010;
    bus.a_in = 4'b0010;
    bus.b_in = 4'b0010;
    step();
    bus.a_in = 4'b0000;
    bus.req  = 4'b0000;
    step();
    total++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 1'b1 ||
        bus.gate_a !== 1'b1) begin
      bad++;
      $display("FAIL latch got rv %b d %b ga %b want 0010 1 1",
               bus.rsp_valid, bus.rsp_data, bus.gate_a);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.req  = 4'b0001;
    bus.a_in = 4'b0001;
    bus.b_in = 4'b0001;
    step();
    rst = 1'b1;
    bus.req = '0;
    step();
    rst = 1'b0;
    total++;
    if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 4'b0000 ||
        bus.txn_count !== 8'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid got g %b rv %b c %0d busy %b want 0",
               bus.gnt, bus.rsp_valid, bus.txn_count, bus.busy);
    end
    step();
    total++;
    if (bus.rsp_valid !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_rv got %b want 0000", bus.rsp_valid);
    end
    bus.req = 4'b1111;
    step();
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid_ptr got %b want 0001", bus.gnt);
    end
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    step();
  endtask

  // count is 1 on entry; a persistent single requester is
  // re-granted every third cycle
  task automatic test_count_wrap();
    int miss;
    miss = 0;
    bus.req = 4'b0001;
    for (int n = 0; n < 254; n++) begin
      step();
      if (bus.gnt !== 4'b0001) miss++;
      step();
      if (bus.rsp_valid !== 4'b0001) miss++;
      step();
    end
    total++;
    if (miss != 0) begin
      bad++;
      $display("FAIL persist got %0d misses want 0", miss);
    end
    total++;
    if (bus.txn_count !== 8'd255) begin
      bad++;
      $display("FAIL cnt255 got %0d want 255", bus.txn_count);
    end
    step();
    step();
    bus.req = '0;
    total++;
    if (bus.txn_count !== 8'd0 || bus.rsp_valid !== 4'b0001) begin
      bad++;
      $display("FAIL cntwrap got %0d rv %b want 0 0001",
               bus.txn_count, bus.rsp_valid);
    end
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_operand_latch();
    test_reset_mid();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
